perf_counter_mc: RTL

Multi-channel successor to the single start/stop latency counter. It measures the cycle latency between a start edge and a stop edge on NCH independent channels, for example trigger-in to trig_out per emulated chip. Each channel keeps last, min, max, saturating sum and sample count. A single registered readout port exposes one channel at a time, selected by `sel`, for the off-chip monitor.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_chan.sv | 130 +++++++++++++
 rtl/perf_counter_mc.sv | 113 +++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared types, reset constants and saturating arithmetic for the
// multi-channel start/stop latency counter.
package perf_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Wide reset patterns; users cast them down to the field width.
   localparam logic [63:0] MIN_RST  = '1;
   localparam logic [63:0] STAT_RST = '0;

   // Sum of two values that live in w-bit fields, clipped at 2^w-1 (w <= 64).
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned w);
      logic [64:0] s;
      logic [64:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (s > lim) ? lim[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/perf_chan.sv
// One latency channel: input edge detect, IDLE/RUN FSM, saturating cycle
// counter and the last/min/max/sum/count statistics.
module perf_chan
   import perf_pkg::*;
#(
   parameter int CW   = 16,
   parameter int SUMW = 32,
   parameter int NW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            start,
   input  logic            stop,
   output logic            busy,
   output logic            done,
   output logic            ovf,
   output logic [CW-1:0]   last_val,
   output logic [CW-1:0]   min_val,
   output logic [CW-1:0]   max_val,
   output logic [SUMW-1:0] sum_val,
   output logic [NW-1:0]   n_val
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t            state_reg, state_next;
   logic              start_q_reg, stop_q_reg;
   logic              start_edge, stop_edge;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic              complete, sat_hit;
   logic              done_reg, ovf_reg;
   logic [CW-1:0]     last_reg, min_reg, max_reg;
   logic [SUMW-1:0]   sum_reg;
   logic [NW-1:0]     n_reg;

   assign start_edge = start & ~start_q_reg;
   assign stop_edge  = stop & ~stop_q_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else if (clr) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A start edge in the same cycle as a stop edge re-arms immediately.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_edge) state_next = RUN;
         RUN:     if (stop_edge && !start_edge) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      complete = 1'b0;
      sat_hit  = 1'b0;
      cnt_next = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start_edge) cnt_next = CW'(1);
         end
         RUN: begin
            if (stop_edge) begin
               complete = 1'b1;
               cnt_next = start_edge ? CW'(1) : '0;
            end else if (cnt_reg == CNT_MAX) begin
               sat_hit = 1'b1;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: cnt_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_q_reg <= 1'b0;
         stop_q_reg  <= 1'b0;
         cnt_reg     <= '0;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         last_reg    <= CW'(STAT_RST);
         min_reg     <= CW'(MIN_RST);
         max_reg     <= CW'(STAT_RST);
         sum_reg     <= SUMW'(STAT_RST);
         n_reg       <= NW'(STAT_RST);
      end else if (clr) begin
         start_q_reg <= 1'b0;
         stop_q_reg  <= 1'b0;
         cnt_reg     <= '0;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         last_reg    <= CW'(STAT_RST);
         min_reg     <= CW'(MIN_RST);
         max_reg     <= CW'(STAT_RST);
         sum_reg     <= SUMW'(STAT_RST);
         n_reg       <= NW'(STAT_RST);
      end else begin
         start_q_reg <= start;
         stop_q_reg  <= stop;
         cnt_reg     <= cnt_next;
         done_reg    <= complete;
         if (sat_hit) ovf_reg <= 1'b1;
         if (complete) begin
            last_reg <= cnt_reg;
            if (cnt_reg < min_reg) min_reg <= cnt_reg;
            if (cnt_reg > max_reg) max_reg <= cnt_reg;
            sum_reg <= SUMW'(sat_add(64'(sum_reg), 64'(cnt_reg), SUMW));
            n_reg   <= NW'(sat_add(64'(n_reg), 64'd1, NW));
         end
      end
   end

   assign busy     = (state_reg == RUN);
   assign done     = done_reg;
   assign ovf      = ovf_reg;
   assign last_val = last_reg;
   assign min_val  = min_reg;
   assign max_val  = max_reg;
   assign sum_val  = sum_reg;
   assign n_val    = n_reg;

endmodule

// File: rtl/perf_counter_mc.sv
// NCH independent start/stop latency channels with a registered readout
// port that shows the statistics of the channel picked by sel.
module perf_counter_mc
   import perf_pkg::*;
#(
   parameter  int NCH  = 4,
   parameter  int CW   = 16,
   parameter  int SUMW = 32,
   parameter  int NW   = 16,
   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic [NCH-1:0]  start,
   input  logic [NCH-1:0]  stop,
   input  logic [SELW-1:0] sel,
   output logic [NCH-1:0]  busy,
   output logic [NCH-1:0]  done,
   output logic [NCH-1:0]  ovf,
   output logic [CW-1:0]   last_val,
   output logic [CW-1:0]   min_val,
   output logic [CW-1:0]   max_val,
   output logic [SUMW-1:0] sum_val,
   output logic [NW-1:0]   n_samples
);

   logic [CW-1:0]   last_arr [NCH];
   logic [CW-1:0]   min_arr  [NCH];
   logic [CW-1:0]   max_arr  [NCH];
   logic [SUMW-1:0] sum_arr  [NCH];
   logic [NW-1:0]   n_arr    [NCH];

   logic [CW-1:0]   last_next, min_next, max_next;
   logic [SUMW-1:0] sum_next;
   logic [NW-1:0]   n_next;

   logic [CW-1:0]   last_reg, min_reg, max_reg;
   logic [SUMW-1:0] sum_reg;
   logic [NW-1:0]   n_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         perf_chan #(
            .CW   (CW),
            .SUMW (SUMW),
            .NW   (NW)
         ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .start    (start[gi]),
            .stop     (stop[gi]),
            .busy     (busy[gi]),
            .done     (done[gi]),
            .ovf      (ovf[gi]),
            .last_val (last_arr[gi]),
            .min_val  (min_arr[gi]),
            .max_val  (max_arr[gi]),
            .sum_val  (sum_arr[gi]),
            .n_val    (n_arr[gi])
         );
      end
   endgenerate

   // A select beyond the last channel matches nothing and reads as reset values.
   always_comb begin
      last_next = CW'(STAT_RST);
      min_next  = CW'(MIN_RST);
      max_next  = CW'(STAT_RST);
      sum_next  = SUMW'(STAT_RST);
      n_next    = NW'(STAT_RST);
      for (int i = 0; i < NCH; i++) begin
         if (sel == SELW'(i)) begin
            last_next = last_arr[i];
            min_next  = min_arr[i];
            max_next  = max_arr[i];
            sum_next  = sum_arr[i];
            n_next    = n_arr[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_reg <= CW'(STAT_RST);
         min_reg  <= CW'(MIN_RST);
         max_reg  <= CW'(STAT_RST);
         sum_reg  <= SUMW'(STAT_RST);
         n_reg    <= NW'(STAT_RST);
      end else if (clr) begin
         last_reg <= CW'(STAT_RST);
         min_reg  <= CW'(MIN_RST);
         max_reg  <= CW'(STAT_RST);
         sum_reg  <= SUMW'(STAT_RST);
         n_reg    <= NW'(STAT_RST);
      end else begin
         last_reg <= last_next;
         min_reg  <= min_next;
         max_reg  <= max_next;
         sum_reg  <= sum_next;
         n_reg    <= n_next;
      end
   end

   assign last_val  = last_reg;
   assign min_val   = min_reg;
   assign max_val   = max_reg;
   assign sum_val   = sum_reg;
   assign n_samples = n_reg;

endmodule
